layer_compositor: RTL and testbench

- Parametrised N-layer sprite/background compositor with a run-time-writable palette, feeding the VGA output stage.
- Each pixel cycle it:
  - picks the highest-priority active layer and issues its address to an external synchronous sprite ROM;
  - aligns the ROM palette index with delayed control;
  - maps the index through a palette register file, applies a global fade, and drives registered RGB.
- Also keeps a sticky per-frame collision flag for game logic.

---
 rtl/layer_compositor_if.sv | 37 +++
 rtl/layer_compositor.sv | 131 +++++++++++++
 tb/tb_layer_compositor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_compositor_if.sv
// Pixel-side bundle between the compositor, its sprite ROM and the
// frame/palette controller.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 8,
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 5
) ();
    localparam int HW = $clog2(NUM_LAYERS) + 1;

    logic [NUM_LAYERS*ADDR_W-1:0] layer_addr;
    logic [NUM_LAYERS-1:0]        layer_draw;
    logic                         blank;
    logic                         frame_start;
    logic [ADDR_W-1:0]            rom_addr;
    logic [IDX_W-1:0]             rom_q;
    logic                         pal_we;
    logic [IDX_W-1:0]             pal_waddr;
    logic [23:0]                  pal_wdata;
    logic [2:0]                   fade;
    logic [7:0]                   Red;
    logic [7:0]                   Green;
    logic [7:0]                   Blue;
    logic [HW-1:0]                hit_layer;
    logic                         collision;

    modport master (
        output layer_addr, layer_draw, blank, frame_start,
        output rom_q, pal_we, pal_waddr, pal_wdata, fade,
        input  rom_addr, Red, Green, Blue, hit_layer, collision
    );

    modport slave (
        input  layer_addr, layer_draw, blank, frame_start,
        input  rom_q, pal_we, pal_waddr, pal_wdata, fade,
        output rom_addr, Red, Green, Blue, hit_layer, collision
    );
endinterface

// File: rtl/layer_compositor.sv
// N-layer priority compositor: picks a sprite ROM address, maps the
// returned index through a writable palette and fades it to RGB.
module layer_compositor #(
    parameter int NUM_LAYERS   = 8,
    parameter int ADDR_W       = 18,
    parameter int IDX_W        = 5,
    parameter int ROM_LAT      = 2,
    parameter int BLANK_ADDR   = 1706,
    parameter int DEFAULT_ADDR = 1704
) (
    input logic              clk,
    input logic              reset,
    layer_compositor_if.slave bus
);
    localparam int HW   = $clog2(NUM_LAYERS) + 1;
    localparam int NPAL = 2 ** IDX_W;

    function automatic logic [7:0] grey(int i);
        return 8'(i << (8 - IDX_W));
    endfunction

    logic [HW-1:0]     win;
    logic [ADDR_W-1:0] sel_addr;
    logic              any_draw;
    logic              multi_draw;

    always_comb begin
        win        = HW'(NUM_LAYERS);
        sel_addr   = ADDR_W'(DEFAULT_ADDR);
        any_draw   = 1'b0;
        multi_draw = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_draw[i]) begin
                win      = HW'(i);
                sel_addr = bus.layer_addr[i*ADDR_W +: ADDR_W];
            end
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            multi_draw = multi_draw | (any_draw & bus.layer_draw[i]);
            any_draw   = any_draw | bus.layer_draw[i];
        end
    end

    assign bus.rom_addr = bus.blank ? sel_addr : ADDR_W'(BLANK_ADDR);

    // Control rides alongside the ROM read; the output register is the
    // final stage, giving ROM_LAT+1 cycles end to end.
    logic [ROM_LAT-1:0] blk_q;
    logic [HW-1:0]      win_q [ROM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                win_q[i] <= HW'(NUM_LAYERS);
            end
        end else begin
            blk_q[0] <= bus.blank;
            win_q[0] <= win;
            for (int i = 1; i < ROM_LAT; i++) begin
                blk_q[i] <= blk_q[i-1];
                win_q[i] <= win_q[i-1];
            end
        end
    end

    logic [23:0] pal_q [NPAL];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= {3{grey(i)}};
            end
        end else if (bus.pal_we) begin
            pal_q[bus.pal_waddr] <= bus.pal_wdata;
        end
    end

    logic [23:0]   pix;
    logic [7:0]    red_d, grn_d, blu_d;
    logic [7:0]    red_q, grn_q, blu_q;
    logic [HW-1:0] hit_d, hit_q;
    logic          coll_d, coll_q;

    always_comb begin
        pix   = pal_q[bus.rom_q];
        red_d = 8'h00;
        grn_d = 8'h00;
        blu_d = 8'h00;
        hit_d = HW'(NUM_LAYERS);
        if (blk_q[ROM_LAT-1]) begin
            red_d = pix[23:16] >> bus.fade;
            grn_d = pix[15:8]  >> bus.fade;
            blu_d = pix[7:0]   >> bus.fade;
            hit_d = win_q[ROM_LAT-1];
        end
    end

    // A fresh overlap on the frame boundary belongs to the new frame.
    always_comb begin
        coll_d = coll_q;
        if (bus.blank && multi_draw) begin
            coll_d = 1'b1;
        end else if (bus.frame_start) begin
            coll_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_q  <= 8'h00;
            grn_q  <= 8'h00;
            blu_q  <= 8'h00;
            hit_q  <= HW'(NUM_LAYERS);
            coll_q <= 1'b0;
        end else begin
            red_q  <= red_d;
            grn_q  <= grn_d;
            blu_q  <= blu_d;
            hit_q  <= hit_d;
            coll_q <= coll_d;
        end
    end

    assign bus.Red       = red_q;
    assign bus.Green     = grn_q;
    assign bus.Blue      = blu_q;
    assign bus.hit_layer = hit_q;
    assign bus.collision = coll_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor with a 2-cycle sprite ROM model
// whose palette index is the low address bits.
module tb_layer_compositor;
    localparam int NL = 8;
    localparam int AW = 18;
    localparam int IW = 5;
    localparam int RL = 2;
    localparam int BA = 1706;
    localparam int DA = 1704;

    typedef struct packed {
        logic       bl;
        logic [3:0] win;
        logic [4:0] idx;
    } rec_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [3:0] hit;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    layer_compositor_if #(.NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW)) bus ();

    layer_compositor #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW),
        .ROM_LAT(RL), .BLANK_ADDR(BA), .DEFAULT_ADDR(DA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [IW-1:0] rq1, rq2;
    always_ff @(posedge clk) begin
        rq1 <= bus.rom_addr[IW-1:0];
        rq2 <= rq1;
    end
    assign bus.rom_q = rq2;

    int errs = 0;
    int checks = 0;

    rec_t  pend[$];
    exp_t  expq[$];
    logic [23:0] m_pal [32];
    logic  m_col;

    logic [NL*AW-1:0] d_la;
    logic [NL-1:0]    d_draw;
    logic             d_blank, d_fs, d_we;
    logic [IW-1:0]    d_wa;
    logic [23:0]      d_wd;
    logic [2:0]       d_fade;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_init();
        pend.delete();
        expq.delete();
        for (int i = 0; i < RL; i++) pend.push_back('{1'b0, 4'd8, 5'd0});
        expq.push_back('{8'h00, 8'h00, 8'h00, 4'd8});
        for (int i = 0; i < 32; i++) begin
            m_pal[i] = {3{8'(i * 8)}};
        end
        m_col = 1'b0;
    endtask

    task automatic step();
        exp_t e;
        rec_t r;
        logic [AW-1:0] ea;
        logic [3:0] w;
        int n;
        logic [23:0] p;
        @(negedge clk);
        if (expq.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = expq.pop_front();
            check("red", 32'(bus.Red), 32'(e.r));
            check("green", 32'(bus.Green), 32'(e.g));
            check("blue", 32'(bus.Blue), 32'(e.b));
            check("hit", 32'(bus.hit_layer), 32'(e.hit));
        end
        check("coll", 32'(bus.collision), 32'(m_col));
        bus.layer_addr  = d_la;
        bus.layer_draw  = d_draw;
        bus.blank       = d_blank;
        bus.frame_start = d_fs;
        bus.pal_we      = d_we;
        bus.pal_waddr   = d_wa;
        bus.pal_wdata   = d_wd;
        bus.fade        = d_fade;
        #1;
        w = 4'd8;
        n = 0;
        for (int i = 0; i < NL; i++) begin
            if (d_draw[i]) begin
                n++;
                if (w == 4'd8) w = 4'(i);
            end
        end
        if (!d_blank) ea = AW'(BA);
        else if (w == 4'd8) ea = AW'(DA);
        else ea = d_la[int'(w)*AW +: AW];
        check("rom_addr", 32'(bus.rom_addr), 32'(ea));
        pend.push_back('{d_blank, w, ea[IW-1:0]});
        if (pend.size() > RL) begin
            r = pend.pop_front();
            if (!r.bl) begin
                e = '{8'h00, 8'h00, 8'h00, 4'd8};
            end else begin
                p = m_pal[r.idx];
                e.r = p[23:16] >> d_fade;
                e.g = p[15:8] >> d_fade;
                e.b = p[7:0] >> d_fade;
                e.hit = r.win;
            end
            expq.push_back(e);
        end
        if (d_blank && n >= 2) m_col = 1'b1;
        else if (d_fs) m_col = 1'b0;
        if (d_we) m_pal[d_wa] = d_wd;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        bus.blank = 1'b0;
        bus.layer_draw = '0;
        bus.pal_we = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        model_init();
    endtask

    task automatic idle();
        d_draw  = '0;
        d_blank = 1'b1;
        d_fs    = 1'b0;
        d_we    = 1'b0;
        d_wa    = '0;
        d_wd    = '0;
        d_fade  = 3'd0;
    endtask

    task automatic set_la(int i, logic [AW-1:0] a);
        d_la[i*AW +: AW] = a;
    endtask

    initial begin
        bus.layer_addr = '0;
        bus.frame_start = 1'b0;
        bus.pal_waddr = '0;
        bus.pal_wdata = '0;
        bus.fade = 3'd0;
        d_la = '0;
        for (int i = 0; i < NL; i++) set_la(i, AW'($urandom));
        idle();
        do_reset(3);

        repeat (4) step();

        set_la(0, {13'h0abc, 5'd31});
        d_draw = 8'b0000_0001;
        repeat (4) step();

        set_la(2, {13'h1234, 5'd9});
        set_la(5, {13'h0777, 5'd17});
        d_draw = 8'b0010_0100;
        repeat (4) step();

        d_blank = 1'b0;
        d_draw = 8'b1111_1111;
        repeat (4) step();

        idle();
        repeat (4) step();

        set_la(0, {13'h0042, 5'd5});
        d_draw = 8'b0000_0001;
        step();
        step();
        d_we = 1'b1;
        d_wa = 5'd5;
        d_wd = 24'hF0737F;
        step();
        d_we = 1'b0;
        repeat (2) step();
        d_fade = 3'd2;
        repeat (2) step();
        d_fade = 3'd7;
        repeat (2) step();
        d_fade = 3'd0;

        d_draw = 8'b0000_0011;
        step();
        d_draw = 8'b0000_0010;
        d_fs = 1'b1;
        step();
        d_fs = 1'b0;
        step();
        d_draw = 8'b0000_0011;
        step();
        d_fs = 1'b1;
        step();
        d_fs = 1'b0;
        d_draw = 8'b0000_0000;
        repeat (3) step();

        for (int k = 0; k < 200; k++) begin
            if ((k % 7) == 0) begin
                for (int i = 0; i < NL; i++) set_la(i, AW'($urandom));
            end
            d_draw  = NL'($urandom) & NL'($urandom);
            d_blank = ($urandom_range(0, 4) != 0);
            d_fs    = ($urandom_range(0, 15) == 0);
            d_we    = ($urandom_range(0, 3) == 0);
            d_wa    = IW'($urandom);
            d_wd    = 24'($urandom);
            d_fade  = 3'($urandom_range(0, 7));
            step();
        end

        idle();
        do_reset(2);
        set_la(0, {13'h0042, 5'd5});
        d_draw = 8'b0000_0001;
        repeat (6) step();
        idle();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
